// File: rtl/uart_rx.sv
// UART receiver: oversampled start-edge detection, mid-bit sampling of 7/8 data bits,
// optional parity and one stop bit; presents each frame with a one-cycle valid pulse.
module uart_rx #(
    parameter int unsigned BAUD_9600_BIT_PER   = 5208,
    parameter int unsigned BAUD_115200_BIT_PER = 434,
    parameter int unsigned CNT_W               = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_ParityEn,
    input  logic       i_Datalength,
    input  logic       i_Baudrate,
    input  logic       i_SerialIn,
    output logic [7:0] o_Data,
    output logic       o_DataValid,
    output logic       o_ParityErr,
    output logic       o_FrameErr,
    output logic       o_Busy
);

    localparam logic [CNT_W-1:0] PER_SLOW = CNT_W'(BAUD_9600_BIT_PER);
    localparam logic [CNT_W-1:0] PER_FAST = CNT_W'(BAUD_115200_BIT_PER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e state_q, state_d;

    logic             rx_meta_q, rx_s_q, rx_d_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             len8_q, len8_d;
    logic             pen_q, pen_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             perr_q, perr_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_out_q, perr_out_d;
    logic             ferr_out_q, ferr_out_d;

    logic [CNT_W-1:0] limit;
    logic             sample;
    logic             last_bit;

    // The start state waits only half a period so later samples land mid-bit.
    always_comb begin
        limit    = (state_q == S_START) ? ((per_q >> 1) - CNT_W'(1)) : (per_q - CNT_W'(1));
        sample   = (state_q != S_IDLE) && (cnt_q == limit);
        last_bit = (bit_idx_q == (len8_q ? 3'd7 : 3'd6));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_d_q     <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            per_q      <= '0;
            len8_q     <= 1'b0;
            pen_q      <= 1'b0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            rx_meta_q  <= i_SerialIn;
            rx_s_q     <= rx_meta_q;
            rx_d_q     <= rx_s_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            len8_q     <= len8_d;
            pen_q      <= pen_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        per_d      = per_q;
        len8_d     = len8_q;
        pen_d      = pen_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;

        if (state_q != S_IDLE) begin
            cnt_d = sample ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_d_q && !rx_s_q) begin
                    state_d = S_START;
                    per_d   = i_Baudrate ? PER_FAST : PER_SLOW;
                    len8_d  = i_Datalength;
                    pen_d   = i_ParityEn;
                    shift_d = '0;
                    perr_d  = 1'b0;
                end
            end
            S_START: begin
                if (sample) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    if (last_bit) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    // Unused bit 7 stays zero in 7-bit mode, so it does not disturb the XOR.
                    perr_d  = rx_s_q ^ (^shift_q);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    data_d     = len8_q ? shift_q : {1'b0, shift_q[6:0]};
                    perr_out_d = pen_q & perr_q;
                    ferr_out_d = ~rx_s_q;
                    valid_d    = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_Busy      = (state_q != S_IDLE);
        o_Data      = data_q;
        o_DataValid = valid_q;
        o_ParityErr = perr_out_q;
        o_FrameErr  = ferr_out_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised frame stimulus for uart_rx with a queue scoreboard; a negedge monitor
// checks each delivered byte, error flags and start-edge-to-valid latency.
module tb_uart_rx;

    localparam int FAST = 16;
    localparam int SLOW = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pe    = 1'b0;
    logic       len   = 1'b1;
    logic       baud  = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] o_Data;
    logic       o_DataValid, o_ParityErr, o_FrameErr, o_Busy;

    uart_rx #(
        .BAUD_9600_BIT_PER  (SLOW),
        .BAUD_115200_BIT_PER(FAST),
        .CNT_W              (13)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .i_ParityEn  (pe),
        .i_Datalength(len),
        .i_Baudrate  (baud),
        .i_SerialIn  (rx),
        .o_Data      (o_Data),
        .o_DataValid (o_DataValid),
        .o_ParityErr (o_ParityErr),
        .o_FrameErr  (o_FrameErr),
        .o_Busy      (o_Busy)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        int unsigned t0;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reference: frame fields derived from the line bits the bench itself puts out.
    task automatic send_frame(input logic [7:0] b, input logic l8, input logic p_en,
                              input logic bd, input logic flip, input logic stopv,
                              input int gap_bits, input logic scramble);
        int         per;
        int         nb;
        exp_t       e;
        logic [7:0] d;
        logic       pbit;
        per  = bd ? FAST : SLOW;
        nb   = l8 ? 8 : 7;
        d    = l8 ? b : {1'b0, b[6:0]};
        pbit = (^d) ^ flip;
        e.data = d;
        e.perr = p_en ? (pbit != (^d)) : 1'b0;
        e.ferr = (stopv == 1'b0);
        e.lat  = 3 + per / 2 + (nb + int'(p_en) + 1) * per;
        len  = l8;
        pe   = p_en;
        baud = bd;
        e.t0 = cyc;
        sb.push_back(e);
        drive(1'b0, per);
        chk("busy_mid_frame", {31'd0, o_Busy}, 32'd1);
        if (scramble) begin
            len  = 1'($urandom);
            pe   = 1'($urandom);
            baud = 1'($urandom);
        end
        for (int i = 0; i < nb; i++) drive(d[i], per);
        if (p_en) drive(pbit, per);
        drive(stopv, per);
        if (gap_bits > 0) drive(1'b1, gap_bits * per);
    endtask

    logic prev_v = 1'b0;
    always @(negedge clock) begin
        exp_t        e;
        int unsigned d;
        if (!reset && o_DataValid) begin
            if (prev_v) begin
                checks++;
                errors++;
                $display("FAIL valid_width: got valid high 2 cycles, required 1");
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pulse data %02h, required none", o_Data);
            end else begin
                e = sb.pop_front();
                chk("data", {24'd0, o_Data}, {24'd0, e.data});
                chk("parity_err", {31'd0, o_ParityErr}, {31'd0, e.perr});
                chk("frame_err", {31'd0, o_FrameErr}, {31'd0, e.ferr});
                d = cyc - e.t0;
                checks++;
                if (d < e.lat || d > e.lat + 1) begin
                    errors++;
                    $display("FAIL latency: got %0d required %0d..%0d", d, e.lat, e.lat + 1);
                end
            end
        end
        prev_v = o_DataValid;
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, {24'd0, o_Data}, 32'd0);
        chk({tag, "_valid"}, {31'd0, o_DataValid}, 32'd0);
        chk({tag, "_perr"}, {31'd0, o_ParityErr}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, o_FrameErr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_Busy}, 32'd0);
    endtask

    initial begin
        logic       seen;
        logic [7:0] rb;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        drive(1'b1, 10);

        // 115200 8N1 0xA5
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0);

        // 9600 7-bit parity, good and bad parity bit
        send_frame(8'h35, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h35, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);

        // Short low glitch: busy rises and falls, no frame
        baud = 1'b1;
        seen = 1'b0;
        rx   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            if (i == 2) rx = 1'b1;
            if (o_Busy) seen = 1'b1;
        end
        for (int i = 0; i < 3 * FAST && o_Busy; i++) begin
            @(posedge clock);
            #1;
        end
        chk("glitch_busy_rise", {31'd0, seen}, 32'd1);
        chk("glitch_busy_fall", {31'd0, o_Busy}, 32'd0);
        drive(1'b1, 2 * FAST);

        // Framing error followed by a break; no re-arm until the line goes high
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b0, 20 * FAST);
        chk("break_no_rearm", {31'd0, o_Busy}, 32'd0);
        drive(1'b1, 2 * FAST);
        send_frame(8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0);

        // Reset in the middle of data bit 3
        len  = 1'b1;
        pe   = 1'b0;
        baud = 1'b1;
        rb   = 8'h96;
        drive(1'b0, FAST);
        for (int i = 0; i < 3; i++) drive(rb[i], FAST);
        drive(rb[3], FAST / 2);
        reset = 1'b1;
        rx    = 1'b1;
        drive(1'b1, 2);
        chk_reset_outputs("midframe_reset");
        reset = 1'b0;
        drive(1'b1, 2 * FAST);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0);

        // Back-to-back frames, single stop bit
        send_frame(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0);

        // Random frames with configuration scrambled mid-frame
        for (int n = 0; n < 24; n++) begin
            logic stopv;
            stopv = ($urandom_range(0, 4) != 0);
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), stopv,
                       stopv ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)), 1'b1);
        end

        for (int i = 0; i < 2000 && sb.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        chk("scoreboard_drain", sb.size(), 32'd0);
        chk("final_busy", {31'd0, o_Busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
